// File: rtl/reg_share_arbiter.sv
// ---------------------------------------------------------------------------
// reg_share_arbiter
//
// Purpose:
//   Round-robin arbiter/sequencer that lets NREQ producers share a single
//   WIDTH-bit state register. One requester is served at a time. Its data
//   slice is captured into a hold register and then committed to q. The
//   requester gets a one-cycle ack when the write is done.
//
// Handshake (req/ack):
//   A requester raises req[i] with its data on wr_data slice i and holds
//   both until it sees ack[i]. It drops req[i] in the cycle ack[i] is high.
//   Dropping req[i] while grant[i] is high but before the capture edge
//   withdraws the request: no write and no ack. Once the data is captured,
//   the write always completes. Data is sampled only on the GRANT edge.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous, active-low reset
//   req          per-requester level request [NREQ]
//   wr_data      packed write data, slice i = wr_data[i*WIDTH +: WIDTH]
//   grant        registered one-hot grant
//   ack          registered one-hot, one-cycle write-complete pulse
//   owner        index of current / most recent grantee
//   busy         high whenever the FSM is not in IDLE
//   q            shared register contents
//   o_dbg_state  FSM state (0 IDLE, 1 GRANT, 2 WRITE, 3 ACK)
//   wr_count     completed-write counter, CNT_W bits (only with WR_CNT_EN)
//
// Optional feature macro: WR_CNT_EN (adds the wr_count port and counter).
// ---------------------------------------------------------------------------
module reg_share_arbiter #(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 8,
    parameter  int CNT_W = 8,
    localparam int OW    = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wr_data,
    output logic [NREQ-1:0]       grant,
    output logic [NREQ-1:0]       ack,
    output logic [OW-1:0]         owner,
    output logic                  busy,
    output logic [WIDTH-1:0]      q,
    output logic [1:0]            o_dbg_state
`ifdef WR_CNT_EN
    ,
    output logic [CNT_W-1:0]      wr_count
`endif
);

    // One extra bit so last_owner + offset cannot overflow before the wrap.
    localparam int SW = OW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_WRITE = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    if (NREQ < 2 || NREQ > 8 || CNT_W < 1) begin : g_bad_params
        $error("reg_share_arbiter: NREQ must be 2..8 and CNT_W at least 1");
    end

    state_t            r_state;
    logic [NREQ-1:0]   r_grant;
    logic [NREQ-1:0]   r_ack;
    logic [OW-1:0]     r_owner;
    logic [OW-1:0]     r_last_owner;
    logic              r_busy;
    logic [WIDTH-1:0]  r_q;
    logic [WIDTH-1:0]  r_hold;

    logic [WIDTH-1:0]  w_slice [NREQ];
    logic [OW-1:0]     w_winner;
    logic [SW-1:0]     w_sum;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            w_slice[i] = wr_data[i*WIDTH +: WIDTH];
        end
    end

    // Round-robin pick: scan offsets from the far end down to 1 so the
    // nearest requester after last_owner is the last one written and wins.
    always_comb begin
        w_winner = '0;
        w_sum    = '0;
        for (int off = NREQ; off >= 1; off--) begin
            w_sum = {1'b0, r_last_owner} + SW'(off);
            if (w_sum >= SW'(NREQ)) begin
                w_sum = w_sum - SW'(NREQ);
            end
            if (req[w_sum[OW-1:0]]) begin
                w_winner = w_sum[OW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_ack        <= '0;
            r_owner      <= '0;
            r_last_owner <= OW'(NREQ - 1);
            r_busy       <= 1'b0;
            r_q          <= '0;
            r_hold       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|req) begin
                        r_grant <= NREQ'(1) << w_winner;
                        r_owner <= w_winner;
                        r_busy  <= 1'b1;
                        r_state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (req[r_owner]) begin
                        r_hold  <= w_slice[r_owner];
                        r_state <= ST_WRITE;
                    end else begin
                        // Withdrawn: last_owner stays, so priority is unchanged.
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_WRITE: begin
                    r_q     <= r_hold;
                    r_ack   <= NREQ'(1) << r_owner;
                    r_grant <= '0;
                    r_state <= ST_ACK;
                end
                ST_ACK: begin
                    r_ack        <= '0;
                    r_last_owner <= r_owner;
                    r_busy       <= 1'b0;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef WR_CNT_EN
    logic [CNT_W-1:0] r_wr_count;

    // Counted on the WRITE->ACK edge, so withdrawn grants never reach it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_count <= '0;
        end else if (r_state == ST_WRITE) begin
            r_wr_count <= r_wr_count + CNT_W'(1);
        end
    end

    assign wr_count = r_wr_count;
`endif

    assign grant       = r_grant;
    assign ack         = r_ack;
    assign owner       = r_owner;
    assign busy        = r_busy;
    assign q           = r_q;
    assign o_dbg_state = r_state;

endmodule
